control_sequencer: RTL and testbench

Hardwired control unit for the Mini SRC CPU. A Moore state machine that steps each instruction through fetch, decode and execute, and drives the datapath strobes. It sits directly upstream of the register select/encode stage and supplies that stage's Gra/Grb/Grc, e_Rin, e_Rout and BAout inputs. It also drives PC, MAR, MDR, IR, Y, Z, HI, LO, CON and I/O port strobes, and handshakes with memory.

---
 rtl/control_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit for the Mini SRC CPU. Steps each instruction
//   through fetch (T0..T2), decode (T3) and execute (T4..T7), and drives the
//   datapath strobes, register-select controls and memory requests.
//
// Ports
//   clock            system clock, rising-edge active
//   reset            synchronous active-high; forces T0, blanks all outputs
//   opcode[4:0]      IR[31:27], valid from T3 onward
//   con_ff           branch condition from CON logic (used in br T6)
//   mem_ready        memory finished the pending Read/Write this cycle
//   stop             halt request, sampled in T0 only
//   Gra/Grb/Grc      register field select to select/encode stage
//   e_Rin/e_Rout/BAout register file enables to select/encode stage
//   PCout..OutPortin datapath strobes
//   Read/Write       memory requests
//   alu_op[4:0]      ALU function
//   run              1 while executing, 0 when halted or in reset
module control_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       mem_ready,
  input  logic       stop,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       e_Rin,
  output logic       e_Rout,
  output logic       BAout,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       Zhighout,
  output logic       Zlowout,
  output logic       Cout,
  output logic       HIin,
  output logic       HIout,
  output logic       LOin,
  output logic       LOout,
  output logic       CONin,
  output logic       InPortout,
  output logic       OutPortin,
  output logic       Read,
  output logic       Write,
  output logic [4:0] alu_op,
  output logic       run
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IMM, C_NEG, C_MUL, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFLO, C_MFHI, C_NOP, C_HALT
  } cls_t;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d, cls_cur;
  logic [4:0] op_q;

  function automatic cls_t decode(input logic [4:0] op);
    cls_t c;
    case (op)
      5'b00000: c = C_LD;
      5'b00001: c = C_LDI;
      5'b00010: c = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: c = C_R;
      5'b01100, 5'b01101, 5'b01110: c = C_IMM;
      5'b01111, 5'b10000: c = C_MUL;
      5'b10001, 5'b10010: c = C_NEG;
      5'b10011: c = C_BR;
      5'b10100: c = C_JAL;
      5'b10101: c = C_JR;
      5'b10110: c = C_IN;
      5'b10111: c = C_OUT;
      5'b11000: c = C_MFLO;
      5'b11001: c = C_MFHI;
      5'b11011: c = C_HALT;
      default:  c = C_NOP;
    endcase
    return c;
  endfunction

  // IR only becomes valid in T3, so T3 decodes the live opcode; later
  // states use the class/opcode captured at the end of T3.
  assign cls_d   = decode(opcode);
  assign cls_cur = (state_q == S_T3) ? cls_d : cls_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_T0: state_d = stop ? S_HALT : S_T1;
      S_T1: state_d = mem_ready ? S_T2 : S_T1;
      S_T2: state_d = S_T3;
      S_T3: begin
        case (cls_cur)
          C_HALT: state_d = S_HALT;
          C_JR, C_IN, C_OUT, C_MFLO, C_MFHI, C_NOP: state_d = S_T0;
          default: state_d = S_T4;
        endcase
      end
      S_T4: state_d = (cls_cur == C_NEG || cls_cur == C_JAL) ? S_T0 : S_T5;
      S_T5: state_d = (cls_cur == C_R || cls_cur == C_IMM || cls_cur == C_LDI) ? S_T0 : S_T6;
      S_T6: begin
        case (cls_cur)
          C_LD:    state_d = mem_ready ? S_T7 : S_T6;
          C_ST:    state_d = S_T7;
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        if (cls_cur == C_LD) state_d = S_T0;
        else                 state_d = mem_ready ? S_T0 : S_T7;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_T0;
      cls_q   <= C_NOP;
      op_q    <= 5'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) begin
        cls_q <= cls_d;
        op_q  <= opcode;
      end
    end
  end

  // Output decode from state (plus captured class). Reset blanks everything
  // combinationally so nothing leaks out in the cycle reset is raised.
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    e_Rin = 1'b0; e_Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    Zhighout = 1'b0; Zlowout = 1'b0; Cout = 1'b0;
    HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0; CONin = 1'b0;
    InPortout = 1'b0; OutPortin = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op = 5'b0;
    run = 1'b0;
    if (!reset) begin
      run = (state_q != S_HALT);
      case (state_q)
        S_T0: if (!stop) begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        end
        S_T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          case (cls_cur)
            C_R, C_IMM:        begin Grb = 1'b1; e_Rout = 1'b1; Yin = 1'b1; end
            C_NEG:             begin Grb = 1'b1; e_Rout = 1'b1; alu_op = opcode; Zin = 1'b1; end
            C_MUL:             begin Gra = 1'b1; e_Rout = 1'b1; Yin = 1'b1; end
            C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            C_BR:              begin Gra = 1'b1; e_Rout = 1'b1; CONin = 1'b1; end
            C_JR:              begin Gra = 1'b1; e_Rout = 1'b1; PCin = 1'b1; end
            C_JAL:             begin PCout = 1'b1; Grb = 1'b1; e_Rin = 1'b1; end
            C_IN:              begin InPortout = 1'b1; Gra = 1'b1; e_Rin = 1'b1; end
            C_OUT:             begin Gra = 1'b1; e_Rout = 1'b1; OutPortin = 1'b1; end
            C_MFLO:            begin LOout = 1'b1; Gra = 1'b1; e_Rin = 1'b1; end
            C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; e_Rin = 1'b1; end
            default: ;
          endcase
        end
        S_T4: begin
          case (cls_cur)
            C_R:               begin Grc = 1'b1; e_Rout = 1'b1; alu_op = op_q; Zin = 1'b1; end
            C_IMM:             begin Cout = 1'b1; alu_op = op_q; Zin = 1'b1; end
            C_NEG:             begin Zlowout = 1'b1; Gra = 1'b1; e_Rin = 1'b1; end
            C_MUL:             begin Grb = 1'b1; e_Rout = 1'b1; alu_op = op_q; Zin = 1'b1; end
            C_LDI, C_LD, C_ST: begin Cout = 1'b1; alu_op = ALU_ADD; Zin = 1'b1; end
            C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
            C_JAL:             begin Gra = 1'b1; e_Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end
        S_T5: begin
          case (cls_cur)
            C_R, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; e_Rin = 1'b1; end
            C_MUL:             begin Zlowout = 1'b1; LOin = 1'b1; end
            C_LD, C_ST:        begin Zlowout = 1'b1; MARin = 1'b1; end
            C_BR:              begin Cout = 1'b1; alu_op = ALU_ADD; Zin = 1'b1; end
            default: ;
          endcase
        end
        S_T6: begin
          case (cls_cur)
            C_MUL: begin Zhighout = 1'b1; HIin = 1'b1; end
            C_LD:  begin Read = 1'b1; MDRin = 1'b1; end
            C_ST:  begin Gra = 1'b1; e_Rout = 1'b1; MDRin = 1'b1; end
            C_BR:  begin Zlowout = 1'b1; PCin = con_ff; end
            default: ;
          endcase
        end
        S_T7: begin
          case (cls_cur)
            C_LD:    begin MDRout = 1'b1; Gra = 1'b1; e_Rin = 1'b1; end
            C_ST:    begin MDRout = 1'b1; Write = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] opcode;
  logic con_ff, mem_ready, stop;
  logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, PCout, PCin, IncPC, MARin;
  logic MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout, Cout;
  logic HIin, HIout, LOin, LOout, CONin, InPortout, OutPortin, Read, Write;
  logic [4:0] alu_op;
  logic run;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset(reset), .opcode(opcode), .con_ff(con_ff),
    .mem_ready(mem_ready), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .Cout(Cout), .HIin(HIin), .HIout(HIout), .LOin(LOin),
    .LOout(LOout), .CONin(CONin), .InPortout(InPortout), .OutPortin(OutPortin),
    .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  logic [32:0] got;
  assign got = {alu_op, run, Write, Read, OutPortin, InPortout, CONin, LOout, LOin,
                HIout, HIin, Cout, Zlowout, Zhighout, Zin, Yin, IRin, MDRout, MDRin,
                MARin, IncPC, PCin, PCout, BAout, e_Rout, e_Rin, Grc, Grb, Gra};

  localparam logic [32:0] GRA  = 33'h1 << 0,  GRB  = 33'h1 << 1,  GRC  = 33'h1 << 2;
  localparam logic [32:0] RIN  = 33'h1 << 3,  ROUT = 33'h1 << 4,  BAO  = 33'h1 << 5;
  localparam logic [32:0] PCO  = 33'h1 << 6,  PCI  = 33'h1 << 7,  INC  = 33'h1 << 8;
  localparam logic [32:0] MARI = 33'h1 << 9,  MDRI = 33'h1 << 10, MDRO = 33'h1 << 11;
  localparam logic [32:0] IRI  = 33'h1 << 12, YI   = 33'h1 << 13, ZI   = 33'h1 << 14;
  localparam logic [32:0] ZHO  = 33'h1 << 15, ZLO  = 33'h1 << 16, CO   = 33'h1 << 17;
  localparam logic [32:0] HII  = 33'h1 << 18, HIO  = 33'h1 << 19, LOI  = 33'h1 << 20;
  localparam logic [32:0] LOO  = 33'h1 << 21, CONI = 33'h1 << 22, INPO = 33'h1 << 23;
  localparam logic [32:0] OUTP = 33'h1 << 24, RD   = 33'h1 << 25, WR   = 33'h1 << 26;
  localparam logic [32:0] RUN  = 33'h1 << 27;

  function automatic logic [32:0] alu(input logic [4:0] a);
    return {a, 28'b0};
  endfunction

  // One expected cycle: required outputs plus the inputs to drive in it.
  typedef struct {
    logic [32:0] v;
    bit          mr, stp, cf;
    logic [4:0]  op;
  } cyc_t;

  cyc_t  q[$];
  int    n_cmp = 0, n_err = 0;
  string cur_tag = "reset";

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [32:0] v, input bit mr, input bit stp, input bit cf,
                      input logic [4:0] op);
    cyc_t e;
    e.v = v; e.mr = mr; e.stp = stp; e.cf = cf; e.op = op;
    q.push_back(e);
  endtask

  // Memory state: w stall cycles with identical strobes, then completion.
  task automatic push_mem(input logic [32:0] v, input int w, input logic [4:0] op);
    for (int i = 0; i < w; i++) push(v, 1'b0, rb(), rb(), op);
    push(v, 1'b1, rb(), rb(), op);
  endtask

  task automatic ex(input logic [32:0] v, input logic [4:0] op);
    push(v | RUN, rb(), rb(), rb(), op);
  endtask

  // Expected cycle sequence of one instruction, straight from the per-opcode table.
  task automatic instr(input logic [4:0] op, input int wf, input int wm, input bit cf);
    push(PCO | MARI | INC | ZI | RUN, rb(), 1'b0, rb(), 5'($urandom));
    push_mem(ZLO | PCI | RD | MDRI | RUN, wf, 5'($urandom));
    push(MDRO | IRI | RUN, rb(), rb(), rb(), 5'($urandom));
    if (op >= 5'd3 && op <= 5'd11) begin
      ex(GRB | ROUT | YI, op); ex(GRC | ROUT | alu(op) | ZI, op); ex(ZLO | GRA | RIN, op);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      ex(GRB | ROUT | YI, op); ex(CO | alu(op) | ZI, op); ex(ZLO | GRA | RIN, op);
    end else if (op == 5'd17 || op == 5'd18) begin
      ex(GRB | ROUT | alu(op) | ZI, op); ex(ZLO | GRA | RIN, op);
    end else if (op == 5'd15 || op == 5'd16) begin
      ex(GRA | ROUT | YI, op); ex(GRB | ROUT | alu(op) | ZI, op);
      ex(ZLO | LOI, op); ex(ZHO | HII, op);
    end else if (op <= 5'd2) begin
      ex(GRB | BAO | YI, op); ex(CO | alu(5'd3) | ZI, op);
      if (op == 5'd1) ex(ZLO | GRA | RIN, op);
      else begin
        ex(ZLO | MARI, op);
        if (op == 5'd0) begin
          push_mem(RD | MDRI | RUN, wm, op); ex(MDRO | GRA | RIN, op);
        end else begin
          ex(GRA | ROUT | MDRI, op); push_mem(MDRO | WR | RUN, wm, op);
        end
      end
    end else begin
      case (op)
        5'd19: begin
          ex(GRA | ROUT | CONI, op); ex(PCO | YI, op); ex(CO | alu(5'd3) | ZI, op);
          push(ZLO | (cf ? PCI : 33'h0) | RUN, rb(), rb(), cf, op);
        end
        5'd21: ex(GRA | ROUT | PCI, op);
        5'd20: begin ex(PCO | GRB | RIN, op); ex(GRA | ROUT | PCI, op); end
        5'd22: ex(INPO | GRA | RIN, op);
        5'd23: ex(GRA | ROUT | OUTP, op);
        5'd24: ex(LOO | GRA | RIN, op);
        5'd25: ex(HIO | GRA | RIN, op);
        5'd27: ex(33'h0, op);
        default: ex(33'h0, op);
      endcase
    end
  endtask

  task automatic step();
    cyc_t e;
    e = q.pop_front();
    opcode = e.op; mem_ready = e.mr; stop = e.stp; con_ff = e.cf;
    @(negedge clock);
    chk(cur_tag, got, e.v);
    @(posedge clock); #1;
  endtask

  task automatic run_q(input string tag);
    cur_tag = tag;
    while (q.size() > 0) step();
  endtask

  task automatic halted_cycles(input int n);
    for (int i = 0; i < n; i++) push(33'h0, rb(), rb(), rb(), 5'($urandom));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = rb(); stop = rb(); con_ff = rb(); opcode = 5'($urandom);
      @(negedge clock);
      chk("in_reset", got, 33'h0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = 5'b0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0;
    do_reset(3);

    instr(5'd3, 0, 0, 0);   run_q("add");
    instr(5'd0, 0, 3, 0);   run_q("ld_wait3");
    instr(5'd19, 0, 0, 0);  run_q("br_cf0");
    instr(5'd19, 0, 0, 1);  run_q("br_cf1");
    instr(5'd31, 0, 0, 0);  run_q("undef");
    instr(5'd2, 2, 1, 0);   run_q("st_waits");

    // stop raised in add T4 must be ignored until the following T0
    instr(5'd3, 0, 0, 0);
    q[4].stp = 1'b1;
    push(RUN, rb(), 1'b1, rb(), 5'($urandom));
    halted_cycles(4);
    run_q("stop_halt");
    do_reset(1);
    instr(5'd21, 0, 0, 0);  run_q("after_halt");

    // halt opcode
    instr(5'd27, 0, 0, 0);
    halted_cycles(3);
    run_q("halt_op");
    do_reset(2);

    // reset during st T7 wait
    instr(5'd2, 0, 5, 0);
    cur_tag = "st_t7";
    for (int i = 0; i < 9; i++) step();
    q.delete();
    do_reset(2);
    instr(5'd20, 0, 0, 0);  run_q("after_st_abort");

    for (int k = 0; k < 80; k++) begin
      logic [4:0] op;
      op = 5'($urandom);
      if (op == 5'd27) op = 5'd26;
      instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
      run_q($sformatf("rand_op%0d", op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
